// File: rtl/conv_acc_writer.sv
// Convolution accumulator / output writer.
// Accumulates signed MAC products per output pixel. On en_save it adds the bias, requantizes
// (arithmetic shift, optional ReLU, saturate to int8) and issues one write per pixel with a
// ready handshake. Define CONV_ACC_RELU_EN to clamp negative results to zero before saturation.
module conv_acc_writer #(
  parameter int unsigned CONV_DIM_OUT = 32,
  parameter int unsigned CONV_OUT_CH  = 32,
  parameter int unsigned ACC_W        = 32,
  parameter int unsigned OUT_SHIFT    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_sum,
  input  logic        en_save,
  input  logic [15:0] prod,
  input  logic [15:0] bias,
  input  logic [7:0]  i,
  input  logic [7:0]  j,
  input  logic [7:0]  k,
  input  logic        wr_ready,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        stall,
  output logic [15:0] pix_cnt,
  output logic        done,
  output logic        err
);

  localparam int unsigned DimSq = CONV_DIM_OUT * CONV_DIM_OUT;
  localparam logic [15:0] LastAddr = 16'(CONV_OUT_CH * DimSq - 1);
  localparam logic signed [ACC_W-1:0] SatMax = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SatMin = ACC_W'(-128);

  typedef enum logic [1:0] {StAcc, StWrite, StDone} state_e;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [15:0]       wr_addr_q, wr_addr_d;
  logic        [7:0]        wr_data_q, wr_data_d;
  logic        [15:0]       pix_cnt_q, pix_cnt_d;
  logic                     err_q, err_d;

  logic signed [ACC_W-1:0]  prod_ext, bias_ext, result, shifted, clamped;
  logic        [15:0]       addr_flat;
  logic        [7:0]        quant;

  assign prod_ext  = ACC_W'($signed(prod));
  assign bias_ext  = ACC_W'($signed(bias));
  // Address arithmetic done modulo 2^16, same as truncating the full product.
  assign addr_flat = 16'(i) * 16'(DimSq) + 16'(j) * 16'(CONV_DIM_OUT) + 16'(k);

  // Closed-pixel value and its int8 requantization (a product arriving with en_save is included).
  always_comb begin
    result  = acc_q + bias_ext + (en_sum ? prod_ext : '0);
    shifted = result >>> OUT_SHIFT;
    clamped = shifted;
`ifdef CONV_ACC_RELU_EN
    if (shifted[ACC_W-1]) clamped = '0;
`else
    clamped = shifted;
`endif
    if (clamped > SatMax)      quant = 8'h7f;
    else if (clamped < SatMin) quant = 8'h80;
    else                       quant = clamped[7:0];
  end

  // Next-state logic for the accumulate / write / done sequence.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    pix_cnt_d = pix_cnt_q;
    err_d     = err_q;
    unique case (state_q)
      StAcc: begin
        if (en_save) begin
          state_d   = StWrite;
          acc_d     = '0;
          wr_addr_d = addr_flat;
          wr_data_d = quant;
        end else if (en_sum) begin
          acc_d = acc_q + prod_ext;
        end
      end
      StWrite: begin
        if (wr_ready) begin
          pix_cnt_d = pix_cnt_q + 16'd1;
          state_d   = (wr_addr_q == LastAddr) ? StDone : StAcc;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: state_d = StAcc;
    endcase
    // Upstream must not drive data while stalled; flag it and ignore the request.
    if ((state_q != StAcc) && (en_sum || en_save)) err_d = 1'b1;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StAcc;
      acc_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pix_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pix_cnt_q <= pix_cnt_d;
      err_q     <= err_d;
    end
  end

  assign wr_en   = (state_q == StWrite);
  assign stall   = (state_q != StAcc);
  assign done    = (state_q == StDone);
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign pix_cnt = pix_cnt_q;
  assign err     = err_q;

endmodule

// File: tb/tb_conv_acc_writer.sv
// Directed bench for conv_acc_writer: two instances (OUT_SHIFT 0 and 4) share one stimulus.
module tb_conv_acc_writer;

  logic        clk = 1'b0;
  logic        reset, en_sum, en_save, wr_ready;
  logic [15:0] prod, bias;
  logic [7:0]  i, j, k;

  logic        wr_en0, stall0, done0, err0, wr_en4, stall4, done4, err4;
  logic [15:0] wr_addr0, pix_cnt0, wr_addr4, pix_cnt4;
  logic signed [7:0] wr_data0, wr_data4;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef CONV_ACC_RELU_EN
  localparam bit Relu = 1'b1;
`else
  localparam bit Relu = 1'b0;
`endif

  always #5 clk = ~clk;

  conv_acc_writer #(.CONV_DIM_OUT(2), .CONV_OUT_CH(2), .ACC_W(32), .OUT_SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .en_sum(en_sum), .en_save(en_save), .prod(prod), .bias(bias),
    .i(i), .j(j), .k(k), .wr_ready(wr_ready), .wr_en(wr_en0), .wr_addr(wr_addr0),
    .wr_data(wr_data0), .stall(stall0), .pix_cnt(pix_cnt0), .done(done0), .err(err0)
  );

  conv_acc_writer #(.CONV_DIM_OUT(2), .CONV_OUT_CH(2), .ACC_W(32), .OUT_SHIFT(4)) dut4 (
    .clk(clk), .reset(reset), .en_sum(en_sum), .en_save(en_save), .prod(prod), .bias(bias),
    .i(i), .j(j), .k(k), .wr_ready(wr_ready), .wr_en(wr_en4), .wr_addr(wr_addr4),
    .wr_data(wr_data4), .stall(stall4), .pix_cnt(pix_cnt4), .done(done4), .err(err4)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input bit v, input int p, input int b,
                       input int ii, input int jj, input int kk);
    en_sum  = s;
    en_save = v;
    prod    = 16'(p);
    bias    = 16'(b);
    i       = 8'(ii);
    j       = 8'(jj);
    k       = 8'(kk);
  endtask

  // Close one pixel with wr_ready high; check the write it produces, then let it complete.
  task automatic pixel(input string tag, input int p, input int ii, input int jj, input int kk,
                       input int exp_addr, input int exp0, input int exp4);
    drive(1'b1, 1'b1, p, 0, ii, jj, kk);
    tick();
    drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
    check({tag, "_wr_en"}, int'(wr_en0), 1);
    check({tag, "_addr"}, int'(wr_addr0), exp_addr);
    check({tag, "_data_s0"}, int'(wr_data0), exp0);
    check({tag, "_data_s4"}, int'(wr_data4), exp4);
    tick();
  endtask

  initial begin
    drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
    wr_ready = 1'b0;
    reset    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_wr_en", int'(wr_en0), 0);
    check("rst_addr", int'(wr_addr0), 0);
    check("rst_data", int'(wr_data0), 0);
    check("rst_stall", int'(stall0), 0);
    check("rst_pix_cnt", int'(pix_cnt0), 0);
    check("rst_done_err", int'({done0, err0}), 0);

    // Accumulate 10+20+30, close with bias 4 at (0,0,1).
    drive(1'b1, 1'b0, 10, 0, 0, 0, 0); tick();
    drive(1'b1, 1'b0, 20, 0, 0, 0, 0); tick();
    drive(1'b1, 1'b0, 30, 0, 0, 0, 0); tick();
    drive(1'b0, 1'b1, 0, 4, 0, 0, 1);  tick();
    drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
    check("acc_wr_en", int'(wr_en0), 1);
    check("acc_addr", int'(wr_addr0), 1);
    check("acc_data_s0", int'(wr_data0), 64);
    check("acc_data_s4", int'(wr_data4), 4);
    check("acc_stall", int'(stall0), 1);
    wr_ready = 1'b1;
    tick();
    check("acc_pix_cnt", int'(pix_cnt0), 1);
    check("acc_stall_rel", int'(stall0), 0);

    // Requantization and saturation: 1000 -> 62 (>>4), -1000 -> -63, 300, -300.
    pixel("q_pos1000", 1000, 0, 0, 0, 0, 127, 62);
    pixel("q_neg1000", -1000, 0, 1, 0, 2, Relu ? 0 : -128, Relu ? 0 : -63);
    pixel("s_pos300", 300, 0, 1, 1, 3, 127, 18);
    pixel("s_neg300", -300, 1, 0, 0, 4, Relu ? 0 : -128, Relu ? 0 : -19);

    // Backpressure: acc 7 + bias 1 = 8 at (1,0,1), wr_ready low 3 cycles, en_sum pulsed.
    wr_ready = 1'b0;
    drive(1'b1, 1'b0, 7, 0, 0, 0, 0); tick();
    drive(1'b0, 1'b1, 0, 1, 1, 0, 1); tick();
    drive(1'b1, 1'b0, 100, 0, 0, 0, 0);
    check("bp_wr_en0", int'(wr_en0), 1);
    tick();
    drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
    check("bp_err", int'(err0), 1);
    tick();
    check("bp_wr_en", int'(wr_en0), 1);
    check("bp_addr", int'(wr_addr0), 5);
    check("bp_data", int'(wr_data0), 8);
    check("bp_stall", int'(stall0), 1);
    check("bp_pix_held", int'(pix_cnt0), 5);
    wr_ready = 1'b1;
    tick();
    check("bp_pix_cnt", int'(pix_cnt0), 6);
    check("bp_err_sticky", int'(err0), 1);

    // Next pixel with bias only: ignored en_sum must have left acc at 0.
    drive(1'b0, 1'b1, 0, 5, 1, 1, 0); tick();
    drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
    check("acc_unchanged", int'(wr_data0), 5);
    check("acc_unch_addr", int'(wr_addr0), 6);
    tick();

    // Last pixel (1,1,1): 2 + bias -1 = 1.
    drive(1'b1, 1'b1, 2, -1, 1, 1, 1); tick();
    drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
    check("last_addr", int'(wr_addr0), 7);
    check("last_data", int'(wr_data0), 1);
    check("last_done_early", int'(done0), 0);
    tick();
    check("done", int'(done0), 1);
    check("done_pix_cnt", int'(pix_cnt0), 8);
    check("done_stall", int'(stall0), 1);
    check("done_wr_en", int'(wr_en0), 0);
    tick();
    tick();
    check("done_held", int'({done0, stall0}), 3);
    check("done_s4", int'({done4, pix_cnt4}), int'({1'b1, 16'd8}));

    // Reset out of DONE clears everything.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_all", int'({wr_en0, stall0, done0, err0, pix_cnt0}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time guard so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100us");
    $fatal(1);
  end

endmodule
